memstage_lsu: RTL and testbench
===============================

MEMSTAGE_LSU -- requirements
Module: memstage_lsu

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: data memory depth in 32-bit words; power of 2, at least 4.
REQ-002 SHALL have parameter MEM_LATENCY, default 2: cycles per memory access; legal range 1..8.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, as decided for this block.
REQ-004 SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ValidM  in  1  M-stage instruction valid; 0 means bubble.
- RegWriteM  in  1  register write enable.
- ResultSrcM  in  2  result select; 01 = load.
- MemWriteM  in  1  store.
- Funct3M  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  32  effective address, or pass-through ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  32  PC+4.
- StallM  out  1  hold the M stage and upstream stages this cycle.
- RegWriteW  out  1  registered write enable.
- ResultSrcW  out  2  registered result select.
- ALUResultW  out  32  registered ALU result / address.
- ReadDataW  out  32  registered, size-extended load data.
- RdW  out  5  registered destination register.
- PCPlus4W  out  32  registered PC+4.
- FaultW  out  1  registered access-fault flag.

Function
REQ-005 A memory op SHALL be ValidM=1 with either MemWriteM=1 or ResultSrcM=01; every other valid instruction is a non-memory op.
REQ-006 Fault conditions SHALL be:
- any memory op with Funct3M in {011, 110, 111};
- half-word access with address bit 0 = 1;
- word access with address bits [1:0] != 00.
REQ-007 The word index SHALL be ALUResultM[log2(MEM_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*MEM_WORDS bytes.
REQ-008 Non-memory ops and faulting memory ops SHALL complete in 1 cycle with no stall: the W register captures the M fields at the next edge.
REQ-009 On a faulting op the W register SHALL capture FaultW=1, RegWriteW=0 and ALUResultW = the faulting address, and the memory SHALL NOT be written.
REQ-010 The access FSM SHALL have two states, IDLE and WAIT, plus a down-counter of width log2(8)+1.
REQ-011 IDLE->WAIT transition:
- condition: a non-faulting memory op is present and MEM_LATENCY>1;
- counter loaded with MEM_LATENCY-2.
REQ-012 WAIT behaviour:
- decrement the counter each cycle;
- WAIT->IDLE when the counter = 0 at the edge.
REQ-013 StallM SHALL be combinational and high:
- in IDLE, when a non-faulting memory op is present and MEM_LATENCY>1;
- throughout WAIT, except the cycle in which the counter = 0.
REQ-014 The access is issued in cycle T and completes in cycle T+MEM_LATENCY-1; M-stage inputs are held stable by upstream while StallM=1.
REQ-015 In every cycle with StallM=1, the W register SHALL load a bubble: all fields 0, including RegWriteW and FaultW.
REQ-016 A store SHALL write memory only at the completion edge, with byte enables from Funct3M and address bits [1:0]:
- SB writes WriteDataM[7:0] into the addressed lane;
- SH writes WriteDataM[15:0] into the addressed half;
- SW writes the full word.
REQ-017 A load SHALL read memory in its completion cycle and extract the addressed byte or half.
REQ-018 Load data SHALL be sign-extended for LB/LH, zero-extended for LBU/LHU, and unchanged for LW, then registered into ReadDataW.
REQ-019 A load in the cycle after a store to the same word SHALL return the newly written data.
REQ-020 With MEM_LATENCY=1, StallM SHALL remain 0 and every op SHALL complete in 1 cycle.
REQ-021 Memory contents SHALL have no reset and are undefined until written.

Reset
REQ-022 Asserting reset SHALL immediately clear all W outputs to 0, set FSM=IDLE, counter=0 and StallM=0.
REQ-023 A store in progress when reset is asserted before its completion edge SHALL NOT modify memory.
REQ-024 After reset is released, the first valid instruction SHALL be treated as a new issue.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- MEM_LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> no stall, ReadDataW=0xDEADBEEF one cycle after the load.
- MEM_LATENCY=3: LW @0x20 -> StallM=1 for 2 cycles, W bubbles for those 2 cycles, then RegWriteW=1 with the data.
- SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> ReadDataW=0xFFFFFF80; LBU -> 0x00000080.
- LH @0x21 -> no stall, FaultW=1, RegWriteW=0, ALUResultW=0x21, memory unchanged.
- MEM_WORDS=64: SW 0x12345678 @0x100 -> LW @0x000 returns 0x12345678 (address wrap).
- MEM_LATENCY=4: assert reset in the second cycle of SW @0x8 -> outputs 0 at once; later LW @0x8 returns the old value.

Source files
------------

// File: rtl/memstage_lsu.sv
// Memory-stage load/store unit: decodes M-stage memory ops, stalls upstream for multi-cycle
// accesses to a local word-organised data memory, and registers the M->W pipeline fields.
module memstage_lsu #(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        FaultW
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam bit          MULTI = (MEM_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = MULTI ? CNT_W'(MEM_LATENCY - 2) : '0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_q [MEM_WORDS];

  logic        reg_write_q, reg_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] read_data_q, read_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        fault_q, fault_d;

  logic             is_store, is_load, mem_op, bad_f3, misalign, fault, mem_ok;
  logic             stall, complete, mem_we;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata, rword, ld_data;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;

  // Decode: a store takes priority if both store and load-select are set.
  always_comb begin
    is_store = ValidM & MemWriteM;
    is_load  = ValidM & ~MemWriteM & (ResultSrcM == 2'b01);
    mem_op   = is_store | is_load;
    bad_f3   = Funct3M inside {3'b011, 3'b110, 3'b111};
    misalign = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
               ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
    fault    = mem_op & (bad_f3 | misalign);
    mem_ok   = mem_op & ~fault;
    idx      = ALUResultM[IDX_W+1:2];
  end

  // Access sequencing; reset forces the idle, non-stalling view immediately.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (mem_ok) begin
            if (MULTI) begin
              stall   = 1'b1;
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end else begin
              complete = 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            complete = mem_ok;
            state_d  = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign StallM = stall;

  // Store lane enables and replicated write data.
  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
    mem_we = complete & is_store;
  end

  // Load extraction and size extension.
  always_comb begin
    rword = mem_q[idx];
    rbyte = rword[{ALUResultM[1:0], 3'b000} +: 8];
    rhalf = ALUResultM[1] ? rword[31:16] : rword[15:0];
    case (Funct3M)
      3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  ld_data = {24'h0, rbyte};
      3'b101:  ld_data = {16'h0, rhalf};
      default: ld_data = rword;
    endcase
  end

  // W register next value: bubble while stalled or for an invalid slot.
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    alu_result_d = '0;
    read_data_d  = '0;
    rd_d         = '0;
    pc_plus4_d   = '0;
    fault_d      = 1'b0;
    if (!stall && ValidM) begin
      result_src_d = ResultSrcM;
      alu_result_d = ALUResultM;
      rd_d         = RdM;
      pc_plus4_d   = PCPlus4M;
      if (fault) begin
        fault_d = 1'b1;
      end else begin
        reg_write_d = RegWriteM;
        if (is_load) read_data_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      fault_q      <= fault_d;
    end
  end

  // Data memory has no reset; stores land only on their completion edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pc_plus4_q;
  assign FaultW     = fault_q;

endmodule

// File: tb/tb_memstage_lsu.sv
// Bench for memstage_lsu: three instances (latency 1, 3, 4) driven by a directed table,
// hand-written reset sequences and random ops checked against a byte-addressed memory model.
module tb_memstage_lsu;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [1:0]  src;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] pc;
  } op_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        fault;
  } out_t;

  typedef struct {
    int   k;
    op_t  op;
    out_t exp;
    int   nst;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  op_t  drv [3];

  logic        stall_o [3];
  logic        rw_o    [3];
  logic [1:0]  src_o   [3];
  logic [31:0] alu_o   [3];
  logic [31:0] rdata_o [3];
  logic [4:0]  rd_o    [3];
  logic [31:0] pc_o    [3];
  logic        fault_o [3];

  logic [7:0] mm [3][256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    memstage_lsu #(.MEM_WORDS(64), .MEM_LATENCY(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .ValidM     (drv[g].valid),
      .RegWriteM  (drv[g].rw),
      .ResultSrcM (drv[g].src),
      .MemWriteM  (drv[g].mw),
      .Funct3M    (drv[g].f3),
      .ALUResultM (drv[g].addr),
      .WriteDataM (drv[g].wdata),
      .RdM        (drv[g].rd),
      .PCPlus4M   (drv[g].pc),
      .StallM     (stall_o[g]),
      .RegWriteW  (rw_o[g]),
      .ResultSrcW (src_o[g]),
      .ALUResultW (alu_o[g]),
      .ReadDataW  (rdata_o[g]),
      .RdW        (rd_o[g]),
      .PCPlus4W   (pc_o[g]),
      .FaultW     (fault_o[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] pre(input int k, input int w);
    return 32'h5A00_0000 + 32'(k) * 32'h0010_0000 + 32'(w) * 32'h0001_0101;
  endfunction

  function automatic op_t mk(input logic rw, input logic [1:0] src, input logic mw,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd,
                             input logic [31:0] pc);
    op_t o;
    o.valid = 1'b1; o.rw = rw; o.src = src; o.mw = mw; o.f3 = f3;
    o.addr = addr; o.wdata = wdata; o.rd = rd; o.pc = pc;
    return o;
  endfunction

  function automatic out_t mo(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input logic [31:0] pc, input logic fault);
    out_t o;
    o.rw = rw; o.src = src; o.alu = alu; o.rdata = rdata; o.rd = rd; o.pc = pc; o.fault = fault;
    return o;
  endfunction

  function automatic out_t get_out(input int k);
    return mo(rw_o[k], src_o[k], alu_o[k], rdata_o[k], rd_o[k], pc_o[k], fault_o[k]);
  endfunction

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: byte-addressed memory wrapping at 256 bytes, latency from the instance.
  task automatic model(input int k, input op_t op, output out_t e, output int nst);
    bit st, ld;
    int sz, base;
    logic [31:0] v;
    e = '0;
    nst = 0;
    if (!op.valid) return;
    st = op.mw;
    ld = !op.mw && (op.src == 2'b01);
    case (op.f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    e.alu = op.addr; e.src = op.src; e.rd = op.rd; e.pc = op.pc;
    if ((st || ld) && (sz == 0 || (int'(op.addr[1:0]) % sz) != 0)) begin
      e.fault = 1'b1;
      return;
    end
    e.rw = op.rw;
    if ((st || ld) && lat_of(k) > 1) nst = lat_of(k) - 1;
    base = int'(op.addr[7:0]);
    if (st) for (int i = 0; i < sz; i++) mm[k][base+i] = 8'(op.wdata >> (8*i));
    if (ld) begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mm[k][base+i]) << (8*i));
      if (op.f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (op.f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end
  endtask

  // Called at a negedge; returns at the negedge after the completion edge.
  task automatic run_op(input string nm, input int k, input op_t op, input out_t exp, input int nst);
    drv[k] = op;
    #1;
    chk_bit({nm, " stall@issue"}, stall_o[k], nst > 0);
    for (int c = 0; c < nst; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out({nm, " bubble"}, get_out(k), '0);
      chk_bit({nm, " stall@wait"}, stall_o[k], (c + 1) < nst);
    end
    @(posedge clk);
    @(negedge clk);
    chk_out(nm, get_out(k), exp);
    drv[k] = '0;
  endtask

  initial begin
    vec_t tbl[$];
    op_t  op, op0;
    out_t e;
    int   n;

    for (int k = 0; k < 3; k++) drv[k] = '0;
    reset = 1'b1;

    // Directed table: latency 1 (k0), 3 (k1), 4 (k2).
    tbl.push_back('{0, mk(0, 2'b00, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 32'h100),
                      mo(0, 2'b00, 32'h10, 32'h0, 5'd0, 32'h100, 0), 0});
    tbl.push_back('{0, mk(1, 2'b01, 0, 3'b010, 32'h10, 32'h0, 5'd5, 32'h104),
                      mo(1, 2'b01, 32'h10, 32'hDEADBEEF, 5'd5, 32'h104, 0), 0});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b010, 32'h20, 32'h0, 5'd6, 32'h200),
                      mo(1, 2'b01, 32'h20, pre(1, 8), 5'd6, 32'h200, 0), 2});
    tbl.push_back('{1, mk(0, 2'b00, 1, 3'b010, 32'h10, 32'h0, 5'd0, 32'h204),
                      mo(0, 2'b00, 32'h10, 32'h0, 5'd0, 32'h204, 0), 2});
    tbl.push_back('{1, mk(0, 2'b00, 1, 3'b000, 32'h13, 32'hABCDEF80, 5'd0, 32'h208),
                      mo(0, 2'b00, 32'h13, 32'h0, 5'd0, 32'h208, 0), 2});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b000, 32'h13, 32'h0, 5'd7, 32'h20C),
                      mo(1, 2'b01, 32'h13, 32'hFFFFFF80, 5'd7, 32'h20C, 0), 2});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b100, 32'h13, 32'h0, 5'd7, 32'h210),
                      mo(1, 2'b01, 32'h13, 32'h00000080, 5'd7, 32'h210, 0), 2});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b001, 32'h21, 32'h0, 5'd8, 32'h300),
                      mo(0, 2'b01, 32'h21, 32'h0, 5'd8, 32'h300, 1), 0});
    tbl.push_back('{1, mk(0, 2'b00, 1, 3'b001, 32'h21, 32'hFFFF, 5'd0, 32'h304),
                      mo(0, 2'b00, 32'h21, 32'h0, 5'd0, 32'h304, 1), 0});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b010, 32'h20, 32'h0, 5'd6, 32'h308),
                      mo(1, 2'b01, 32'h20, pre(1, 8), 5'd6, 32'h308, 0), 2});
    tbl.push_back('{0, mk(0, 2'b00, 1, 3'b010, 32'h100, 32'h12345678, 5'd0, 32'h400),
                      mo(0, 2'b00, 32'h100, 32'h0, 5'd0, 32'h400, 0), 0});
    tbl.push_back('{0, mk(1, 2'b01, 0, 3'b010, 32'h000, 32'h0, 5'd9, 32'h404),
                      mo(1, 2'b01, 32'h000, 32'h12345678, 5'd9, 32'h404, 0), 0});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b001, 32'h12, 32'h0, 5'd10, 32'h408),
                      mo(1, 2'b01, 32'h12, 32'hFFFF8000, 5'd10, 32'h408, 0), 2});
    tbl.push_back('{1, mk(1, 2'b01, 0, 3'b101, 32'h12, 32'h0, 5'd10, 32'h40C),
                      mo(1, 2'b01, 32'h12, 32'h00008000, 5'd10, 32'h40C, 0), 2});
    tbl.push_back('{2, mk(1, 2'b10, 0, 3'b010, 32'h777, 32'h0, 5'd3, 32'h500),
                      mo(1, 2'b10, 32'h777, 32'h0, 5'd3, 32'h500, 0), 0});
    tbl.push_back('{2, mk(1, 2'b01, 0, 3'b011, 32'h40, 32'h0, 5'd4, 32'h504),
                      mo(0, 2'b01, 32'h40, 32'h0, 5'd4, 32'h504, 1), 0});
    op = mk(1, 2'b01, 0, 3'b010, 32'h44, 32'h0, 5'd4, 32'h508);
    op.valid = 1'b0;
    tbl.push_back('{2, op, '0, 0});

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("reset out k%0d", k), get_out(k), '0);
      chk_bit($sformatf("reset stall k%0d", k), stall_o[k], 1'b0);
    end
    reset = 1'b0;

    // Define every memory word before any load.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 64; w++) begin
        op = mk(0, 2'b00, 1, 3'b010, 32'(w * 4), pre(k, w), 5'd0, 32'h0);
        model(k, op, e, n);
        run_op($sformatf("fill k%0d w%0d", k, w), k, op, e, n);
      end
    end

    foreach (tbl[i]) begin
      model(tbl[i].k, tbl[i].op, e, n);
      run_op($sformatf("vec%0d", i), tbl[i].k, tbl[i].op, tbl[i].exp, tbl[i].nst);
    end

    // Reset mid-store on the latency-4 instance while k0 holds a live W value.
    op0 = mk(1, 2'b11, 0, 3'b000, 32'hCAFE, 32'h0, 5'd17, 32'h600);
    op  = mk(0, 2'b00, 1, 3'b010, 32'h8, 32'hCAFEF00D, 5'd0, 32'h604);
    drv[0] = op0;
    drv[2] = op;
    #1;
    chk_bit("rst seq stall@issue", stall_o[2], 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk_bit("rst seq stall cycle2", stall_o[2], 1'b1);
    chk_out("rst seq k0 live", get_out(0), mo(1, 2'b11, 32'hCAFE, 32'h0, 5'd17, 32'h600, 0));
    reset = 1'b1;
    #1;
    chk_out("rst seq k0 cleared", get_out(0), '0);
    chk_bit("rst seq stall cleared", stall_o[2], 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drv[0] = '0;
    drv[2] = '0;
    chk_out("rst seq k2 held", get_out(2), '0);
    reset = 1'b0;
    op = mk(1, 2'b01, 0, 3'b010, 32'h8, 32'h0, 5'd12, 32'h608);
    run_op("rst seq old data", 2, op, mo(1, 2'b01, 32'h8, pre(2, 2), 5'd12, 32'h608, 0), 3);

    // Random ops against the model.
    for (int t = 0; t < 200; t++) begin
      int k, kind;
      k = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 2));
      op.valid = ($urandom_range(0, 7) != 0);
      op.rw    = 1'($urandom_range(0, 1));
      op.mw    = (kind == 1);
      if (kind == 0) op.src = 2'b01;
      else begin
        op.src = 2'($urandom_range(0, 2));
        if (op.src == 2'b01) op.src = 2'b11;
      end
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: op.f3 = 3'b000;
          1: op.f3 = 3'b001;
          2: op.f3 = 3'b010;
          3: op.f3 = 3'b100;
          default: op.f3 = 3'b101;
        endcase
      end else begin
        op.f3 = 3'($urandom_range(0, 7));
      end
      op.addr = $urandom;
      if ($urandom_range(0, 1) != 0) op.addr[1:0] = 2'b00;
      op.wdata = $urandom;
      op.rd    = 5'($urandom_range(0, 31));
      op.pc    = $urandom;
      model(k, op, e, n);
      run_op($sformatf("rand%0d k%0d", t, k), k, op, e, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
